// File: rtl/upuart_rx_fifo_pkg.sv
// Shared upuart definitions: byte width and receive FIFO sizing.
package upuart_rx_fifo_pkg;

  localparam int unsigned UPUART_DATA_W            = 8;
  localparam int unsigned UPUART_RXFIFO_DEPTH_LOG2 = 4;

endpackage

// File: rtl/upuart_fifo_mem.sv
// Simple storage array: one synchronous write port, one asynchronous read port, no reset.
module upuart_fifo_mem #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/upuart_rx_fifo.sv
// Receive byte FIFO for the upuart: first-word-fall-through head, sticky overflow flag.
module upuart_rx_fifo
  import upuart_rx_fifo_pkg::*;
#(
  parameter int unsigned DEPTH_LOG2 = UPUART_RXFIFO_DEPTH_LOG2
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic [UPUART_DATA_W-1:0] i_data_in,
  input  logic                     i_data_wr,
  input  logic                     i_rd,
  input  logic                     i_flush,
  input  logic                     i_ovf_clr,
  output logic [UPUART_DATA_W-1:0] o_data_out,
  output logic                     o_valid,
  output logic                     o_full,
  output logic [DEPTH_LOG2:0]      o_count,
  output logic                     o_ovf
);

  localparam int unsigned CW    = DEPTH_LOG2 + 1;
  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [DEPTH_LOG2-1:0] r_wptr, r_rptr;
  logic [CW-1:0]         r_count;
  logic                  r_ovf;

  logic                  w_full, w_valid;
  logic                  w_pop, w_push, w_ovf_set;
  logic [DEPTH_LOG2-1:0] w_wptr_nxt, w_rptr_nxt;
  logic [CW-1:0]         w_count_nxt;
  logic                  w_ovf_nxt;

  assign w_valid = (r_count != '0);
  assign w_full  = (r_count == CW'(DEPTH));

  // A pop frees a slot in the same cycle, so a write against a full FIFO is accepted alongside rd.
  assign w_pop     = i_rd & w_valid & ~i_flush;
  assign w_push    = i_data_wr & (~w_full | i_rd) & ~i_flush;
  assign w_ovf_set = i_data_wr & w_full & ~i_rd & ~i_flush;

  always_comb begin
    w_wptr_nxt  = r_wptr;
    w_rptr_nxt  = r_rptr;
    w_count_nxt = r_count;
    w_ovf_nxt   = w_ovf_set | (r_ovf & ~i_ovf_clr);
    if (i_flush) begin
      w_wptr_nxt  = '0;
      w_rptr_nxt  = '0;
      w_count_nxt = '0;
    end else begin
      if (w_push) begin
        w_wptr_nxt = r_wptr + 1'b1;
      end
      if (w_pop) begin
        w_rptr_nxt = r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        w_count_nxt = r_count + CW'(1);
      end else if (w_pop && !w_push) begin
        w_count_nxt = r_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  upuart_fifo_mem #(
    .WIDTH  (UPUART_DATA_W),
    .ADDR_W (DEPTH_LOG2)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push),
    .i_waddr (r_wptr),
    .i_wdata (i_data_in),
    .i_raddr (r_rptr),
    .o_rdata (o_data_out)
  );

  assign o_valid = w_valid;
  assign o_full  = w_full;
  assign o_count = r_count;
  assign o_ovf   = r_ovf;

endmodule

// File: doc/upuart_rx_fifo.md
UPUART_RX_FIFO -- requirements
Module: upuart_rx_fifo

Interface
REQ-001 Parameter: DEPTH_LOG2, default 4, log2 of FIFO depth (16 entries).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 nrst  input  1  reset, asynchronous, active-low.
REQ-004 data_in  input  8  received byte from upstream UART receiver.
REQ-005 data_wr  input  1  one-cycle strobe; data_in valid.
REQ-006 rd  input  1  consumer pop request.
REQ-007 flush  input  1  synchronous clear of stored contents.
REQ-008 ovf_clr  input  1  clears sticky overflow flag.
REQ-009 data_out  output  8  head byte, first-word-fall-through.
REQ-010 valid  output  1  FIFO non-empty; data_out meaningful.
REQ-011 full  output  1  count == 2^DEPTH_LOG2.
REQ-012 count  output  DEPTH_LOG2+1  stored byte count.
REQ-013 ovf  output  1  sticky overflow flag.

Function
REQ-014 Circular buffer of 2^DEPTH_LOG2 bytes; write pointer, read pointer, each DEPTH_LOG2 bits, wrap modulo depth.
REQ-015 Write accepted when data_wr=1 and (full=0 or rd=1); byte stored at write pointer, pointer increments.
REQ-016 Pop occurs when rd=1 and valid=1; read pointer increments; rd with valid=0 ignored, no state change.
REQ-017 data_out = entry at read pointer, combinational from registered state; visible the cycle after the write edge (write-to-valid latency 1 cycle).
REQ-018 data_out undefined-but-stable when valid=0; bench does not check it.
REQ-019 count: +1 on write only, -1 on pop only, unchanged on simultaneous write+pop.
REQ-020 Full and write+pop same cycle: both proceed, count stays at depth, no overflow.
REQ-021 Empty and write+rd same cycle: write accepted, rd ignored; count becomes 1.
REQ-022 Full, data_wr=1, rd=0: byte dropped, contents unchanged, ovf set next cycle.
REQ-023 ovf sticky until ovf_clr=1; simultaneous overflow and ovf_clr: set wins.
REQ-024 flush=1: pointers and count zero next cycle; concurrent data_wr and rd discarded; ovf unaffected.
REQ-025 valid, full derived from count; no extra latency.
REQ-026 No combinational path from data_wr or rd to any output.

Reset
REQ-027 nrst low: pointers 0, count 0, valid 0, full 0, ovf 0, immediately and asynchronously.
REQ-028 Reset mid-operation discards stored bytes; storage array not reset.
REQ-029 First write accepted on first rising edge after nrst release.

Structure
REQ-030 Default depth constant UPUART_RXFIFO_DEPTH_LOG2 in shared UART definitions header alongside other upuart constants.
REQ-031 Storage array in sub-module upuart_fifo_mem (1 write port, 1 async read port, parameterised width/depth); control logic in upuart_rx_fifo.
REQ-032 Ports connect directly: upuart_rx data_out/data_wr -> data_in/data_wr.

Verification
REQ-033 Write 0x41,0x42,0x43 on separate strobes, rd=0 -> count=3, valid=1, data_out=0x41; then three pops -> 0x42, 0x43, then valid=0, count=0.
REQ-034 Write 16 bytes 0x00..0x0F -> full=1, count=16; 17th write 0xAA -> ovf=1, count=16; drain order 0x00..0x0F, 0xAA never seen.
REQ-035 Full FIFO, data_wr=1 (0x55) with rd=1 -> no ovf, count=16, 0x55 last out after draining.
REQ-036 Empty, data_wr=1 (0x7E) with rd=1 -> count=1, data_out=0x7E next cycle.
REQ-037 ovf=1, assert ovf_clr with simultaneous overflow write -> ovf stays 1; ovf_clr alone -> ovf=0.
REQ-038 Load 5 bytes, pulse flush with data_wr=1 -> count=0, valid=0; assert nrst low mid-traffic -> all outputs zero immediately; wrap test: 40 write/pop pairs preserve order.
